// File: rtl/uart_tx.sv
// FIFO-fed UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to add a parity bit (odd/even chosen by parity_odd).
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StParity, StStop} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  period_q, period_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  txd_q, txd_d;
    logic                  rd_en_q, rd_en_d;
    logic                  done_q, done_d;
    logic                  bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign bit_end = (cnt_q == period_q - DIV_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            period_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            rd_en_q  <= rd_en_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        rd_en_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            // The pop strobe is registered, so it is raised one IDLE cycle ahead of FETCH;
            // the pop decision for a back-to-back frame is taken on the last stop clock.
            StIdle: begin
                if (rd_en_q) begin
                    state_d = StFetch;
                end else begin
                    rd_en_d = tx_en & ~fifo_empty;
                end
            end
            StFetch: begin
                shift_d  = fifo_dout;
                period_d = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
                cnt_d    = '0;
                state_d  = StStart;
`ifdef UART_TX_PARITY_EN
                par_d    = (^fifo_dout) ^ parity_odd;
`endif
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == IdxW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    rd_en_d = tx_en & ~fifo_empty;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line outputs are computed from next-state values so they leave flops in step.
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: txd_d = par_q;
`endif
            default:  txd_d = 1'b1;
        endcase
        done_d = (state_d == StStop) && (cnt_d == period_d - DIV_WIDTH'(1));
    end

    assign fifo_rd_en = rd_en_q;
    assign txd        = txd_q;
    assign tx_done    = done_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model plus scoreboard of pushed bytes,
// decoded from txd by a bit-period-aware receiver.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int ParBits = 1;
`else
    localparam int ParBits = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_en;
    logic [15:0]   baud_div;
    logic          parity_odd;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic          txd;
    logic          busy;
    logic          tx_done;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(DW), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .baud_div   (baud_div),
        .parity_odd (parity_odd),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .txd        (txd),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    int            rd_cnt = 0;
    int            rd_viol = 0;
    int            done_cnt = 0;
    bit            rd_prev = 1'b0;
    int            baud_chg_cyc = -1;
    logic [15:0]   baud_chg_val = 16'd0;
    int            en_off_cyc = -1;

    logic [DW-1:0] rx_data;
    int            rx_gap, rx_len, rx_err;
    bit            rx_tmo;
`ifdef UART_TX_PARITY_EN
    logic          rx_par;
`endif

    // One clock: FIFO pops on the strobe seen during the cycle, read data appears next cycle.
    task automatic tick();
        logic pop;
        pop = fifo_rd_en;
        if (pop === 1'b1) begin
            rd_cnt++;
            if (fifo_empty === 1'b1 || busy === 1'b1 || rd_prev) rd_viol++;
        end
        rd_prev = (pop === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (pop === 1'b1 && fifo_mem.size() > 0) fifo_dout = fifo_mem.pop_front();
        fifo_empty = (fifo_mem.size() == 0);
        if (cyc == baud_chg_cyc) baud_div = baud_chg_val;
        if (cyc == en_off_cyc) tx_en = 1'b0;
        if (tx_done === 1'b1) done_cnt++;
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_mem.push_back(b);
        exp_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then checks every clock of the frame.
    task automatic rx_frame(input int period);
        int   start_cyc;
        logic b;
        rx_err = 0; rx_gap = 0; rx_tmo = 1'b0; rx_data = '0; rx_len = 0;
        tick();
        while (txd !== 1'b0 && rx_gap < 500) begin
            rx_gap++;
            tick();
        end
        if (txd !== 1'b0) begin
            rx_tmo = 1'b1;
            return;
        end
        start_cyc = cyc;
        if (tx_done !== 1'b0) rx_err++;
        for (int i = 1; i < period; i++) begin
            tick();
            if (txd !== 1'b0 || tx_done !== 1'b0) rx_err++;
        end
        for (int k = 0; k < DW; k++) begin
            tick();
            b = txd;
            if (tx_done !== 1'b0) rx_err++;
            for (int i = 1; i < period; i++) begin
                tick();
                if (txd !== b || tx_done !== 1'b0) rx_err++;
            end
            rx_data[k] = b;
        end
`ifdef UART_TX_PARITY_EN
        tick();
        rx_par = txd;
        for (int i = 1; i < period; i++) begin
            tick();
            if (txd !== rx_par || tx_done !== 1'b0) rx_err++;
        end
`endif
        for (int i = 0; i < period; i++) begin
            tick();
            if (txd !== 1'b1) rx_err++;
            if (tx_done !== (i == period - 1)) rx_err++;
        end
        rx_len = cyc - start_cyc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); else n_pass++;
        n_checks++; if (tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [DW-1:0] e;
        int rd0, dn0, v0;
        tx_en = 1'b1; baud_div = 16'd4;
        rd0 = rd_cnt; dn0 = done_cnt; v0 = rd_viol;
        push(8'h55);
        rx_frame(4);
        e = exp_q.pop_front();
        n_checks++; if (rx_tmo) $display("FAIL single_timeout: no start bit seen"); else n_pass++;
        n_checks++; if (rx_data !== e) $display("FAIL single_data: got %h want %h", rx_data, e); else n_pass++;
        n_checks++; if (rx_err != 0) $display("FAIL single_shape: got %0d bad clocks want 0", rx_err); else n_pass++;
        n_checks++; if (rx_len != 4 * (DW + 2 + ParBits))
            $display("FAIL single_len: got %0d want %0d", rx_len, 4 * (DW + 2 + ParBits)); else n_pass++;
        n_checks++; if (done_cnt - dn0 != 1) $display("FAIL single_done_cnt: got %0d want 1", done_cnt - dn0); else n_pass++;
        n_checks++; if (rd_cnt - rd0 != 1) $display("FAIL single_rd_cnt: got %0d want 1", rd_cnt - rd0); else n_pass++;
        n_checks++; if (rd_viol != v0) $display("FAIL single_rd_viol: got %0d want %0d", rd_viol, v0); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [DW-1:0] e;
        for (int k = 0; k < 2; k++) begin
            parity_odd = (k == 1);
            push(8'h55);
            rx_frame(4);
            e = exp_q.pop_front();
            n_checks++; if (rx_data !== e) $display("FAIL parity_data%0d: got %h want %h", k, rx_data, e); else n_pass++;
            n_checks++; if (rx_par !== ((^e) ^ (k == 1)))
                $display("FAIL parity_bit%0d: got %b want %b", k, rx_par, (^e) ^ (k == 1)); else n_pass++;
            n_checks++; if (rx_len != 44) $display("FAIL parity_len%0d: got %0d want 44", k, rx_len); else n_pass++;
        end
        parity_odd = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [DW-1:0] e;
        int rd0, v0;
        tx_en = 1'b0;
        push(8'hA1); push(8'hB2); push(8'hC3);
        rd0 = rd_cnt; v0 = rd_viol;
        repeat (6) tick();
        n_checks++; if (rd_cnt != rd0) $display("FAIL b2b_gated: got %0d pops want 0", rd_cnt - rd0); else n_pass++;
        tx_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rx_frame(4);
            e = exp_q.pop_front();
            n_checks++; if (rx_data !== e) $display("FAIL b2b_data%0d: got %h want %h", k, rx_data, e); else n_pass++;
            n_checks++; if (rx_err != 0) $display("FAIL b2b_shape%0d: got %0d bad clocks want 0", k, rx_err); else n_pass++;
            if (k > 0) begin
                n_checks++; if (rx_gap != 2) $display("FAIL b2b_gap%0d: got %0d want 2", k, rx_gap); else n_pass++;
            end
        end
        n_checks++; if (rd_cnt - rd0 != 3) $display("FAIL b2b_rd_cnt: got %0d want 3", rd_cnt - rd0); else n_pass++;
        n_checks++; if (rd_viol != v0) $display("FAIL b2b_rd_viol: got %0d want %0d", rd_viol, v0); else n_pass++;
    endtask

    task automatic test_idle();
        int bad, rd0;
        tx_en = 1'b1; bad = 0; rd0 = rd_cnt;
        repeat (100) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL idle_outputs: got %0d bad clocks want 0", bad); else n_pass++;
        n_checks++; if (rd_cnt != rd0) $display("FAIL idle_rd_cnt: got %0d want 0", rd_cnt - rd0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] e;
        int w, rd0, dn0, hi_bad;
        tx_en = 1'b1; baud_div = 16'd4; w = 0;
        push(8'h3C);
        tick();
        while (txd !== 1'b0 && w < 50) begin w++; tick(); end
        n_checks++; if (txd !== 1'b0) $display("FAIL rstmid_start: got txd %b want 0", txd); else n_pass++;
        repeat (4 + 3 * 4 + 1) tick();
        dn0 = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (txd !== 1'b1) $display("FAIL rstmid_txd: got %b want 1", txd); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        void'(exp_q.pop_front());
        rd0 = rd_cnt; hi_bad = 0;
        repeat (20) begin
            tick();
            if (txd !== 1'b1) hi_bad++;
        end
        n_checks++; if (rd_cnt != rd0) $display("FAIL rstmid_no_pop: got %0d want 0", rd_cnt - rd0); else n_pass++;
        n_checks++; if (hi_bad != 0 || done_cnt != dn0)
            $display("FAIL rstmid_quiet: got %0d low clocks %0d dones want 0 0", hi_bad, done_cnt - dn0); else n_pass++;
        push(8'h0F);
        rx_frame(4);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e) $display("FAIL rstmid_next_data: got %h want %h", rx_data, e); else n_pass++;
        n_checks++; if (rx_err != 0) $display("FAIL rstmid_next_shape: got %0d want 0", rx_err); else n_pass++;
    endtask

    task automatic test_baud();
        logic [DW-1:0] e;
        tx_en = 1'b1; baud_div = 16'd0;
        push(8'hC6);
        rx_frame(2);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e || rx_err != 0)
            $display("FAIL baud0_data: got %h (%0d bad) want %h", rx_data, rx_err, e); else n_pass++;
        n_checks++; if (rx_len != 2 * (DW + 2 + ParBits))
            $display("FAIL baud0_len: got %0d want %0d", rx_len, 2 * (DW + 2 + ParBits)); else n_pass++;
        baud_div = 16'd4; baud_chg_val = 16'd8; baud_chg_cyc = cyc + 12;
        push(8'h96);
        rx_frame(4);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e || rx_err != 0)
            $display("FAIL baudchg_data: got %h (%0d bad) want %h", rx_data, rx_err, e); else n_pass++;
        n_checks++; if (rx_len != 4 * (DW + 2 + ParBits))
            $display("FAIL baudchg_len: got %0d want %0d", rx_len, 4 * (DW + 2 + ParBits)); else n_pass++;
        baud_chg_cyc = -1;
        push(8'h3A);
        rx_frame(8);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e || rx_err != 0)
            $display("FAIL baud8_data: got %h (%0d bad) want %h", rx_data, rx_err, e); else n_pass++;
        n_checks++; if (rx_len != 8 * (DW + 2 + ParBits))
            $display("FAIL baud8_len: got %0d want %0d", rx_len, 8 * (DW + 2 + ParBits)); else n_pass++;
        baud_div = 16'd4;
    endtask

    task automatic test_en_gate();
        logic [DW-1:0] e;
        int rd0;
        tx_en = 1'b1; rd0 = rd_cnt;
        en_off_cyc = cyc + 10;
        push(8'hE7); push(8'h18);
        rx_frame(4);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e || rx_err != 0)
            $display("FAIL engate_first: got %h (%0d bad) want %h", rx_data, rx_err, e); else n_pass++;
        repeat (10) tick();
        n_checks++; if (rd_cnt - rd0 != 1 || busy !== 1'b0)
            $display("FAIL engate_held: got %0d pops busy %b want 1 0", rd_cnt - rd0, busy); else n_pass++;
        en_off_cyc = -1;
        tx_en = 1'b1;
        rx_frame(4);
        e = exp_q.pop_front();
        n_checks++; if (rx_data !== e || rx_err != 0)
            $display("FAIL engate_second: got %h (%0d bad) want %h", rx_data, rx_err, e); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b0; baud_div = 16'd4; parity_odd = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;
        test_reset();
        test_single();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_baud();
        test_en_gate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the data bits per frame.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, giving the width of baud_div.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-005 SHALL have port tx_en, input, 1, which permits the start of new frames.
REQ-006 SHALL have port baud_div, input, DIV_WIDTH, giving the clocks per bit.
REQ-007 SHALL have port parity_odd, input, 1, where 1 selects odd parity and 0 selects even; it is ignored unless parity is compiled in.
REQ-008 SHALL have port fifo_empty, input, 1, the empty flag of the TX FIFO.
REQ-009 SHALL have port fifo_dout, input, DATA_WIDTH, the FIFO read data, valid 1 cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_rd_en, output, 1, a one-cycle FIFO pop strobe.
REQ-011 SHALL have port txd, output, 1, the serial line, which idles high.
REQ-012 SHALL have port busy, output, 1, which is high in every state except IDLE.
REQ-013 SHALL have port tx_done, output, 1, a one-cycle pulse on the last clock of the stop bit.

Function
REQ-014 SHALL implement the states IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-015 In IDLE, when tx_en=1 and fifo_empty=0, the block SHALL assert fifo_rd_en for exactly 1 cycle and go to FETCH; otherwise it stays in IDLE with fifo_rd_en=0.
REQ-016 In FETCH (1 cycle), the block SHALL load fifo_dout into the shift register, latch the bit period, and go to START.
REQ-017 The bit period SHALL be max(baud_div, 2) clocks, latched in FETCH; changes to baud_div mid-frame have no effect on the current frame.
REQ-018 In START, txd SHALL be 0 for one bit period.
REQ-019 In DATA, the block SHALL send DATA_WIDTH bits LSB first, one bit period each.
REQ-020 The bit index SHALL count 0..DATA_WIDTH-1 with no wrap past the last bit.
REQ-021 PARITY (compiled-in only) SHALL send one bit, one bit period, equal to the XOR of the data bits, inverted when parity_odd=1.
REQ-022 In STOP, txd SHALL be 1 for one bit period, and tx_done SHALL be 1 on its final clock; the next state is IDLE.
REQ-023 Back-to-back frames SHALL be separated by exactly 2 extra clocks of txd=1 (the IDLE and FETCH cycles) beyond the stop bit.
REQ-024 In IDLE and FETCH, txd SHALL be 1.
REQ-025 Deasserting tx_en mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-026 fifo_rd_en SHALL never assert while fifo_empty=1 or while busy=1.
REQ-027 txd, fifo_rd_en and tx_done SHALL be driven from registers (glitch-free).

Reset
REQ-028 On any clock edge with rst=1, including mid-frame, the block SHALL set state=IDLE, txd=1, busy=0, fifo_rd_en=0, tx_done=0, and clear the counters and the shift register.
REQ-029 A frame interrupted by reset SHALL NOT be resumed, and its FIFO entry is lost.

Configuration
REQ-030 Macro UART_TX_PARITY_EN, when defined, SHALL include the PARITY state, giving frame = start + DATA_WIDTH + parity + stop.
REQ-031 Without UART_TX_PARITY_EN, the block SHALL go from DATA directly to STOP, parity_odd SHALL be unused, and frame = start + DATA_WIDTH + stop.

Verification (DATA_WIDTH=8, baud_div=4)
REQ-032 Bench SHALL apply FIFO 0x55 with tx_en=1 and check: rd_en pulses 1 cycle; txd=0 for 4 clk, then bits 1,0,1,0,1,0,1,0 at 4 clk each, then 1 for 4 clk; tx_done pulses once; 40 clk from START to IDLE (no parity).
REQ-033 Bench SHALL, with UART_TX_PARITY_EN, send 0x55 twice, with parity_odd=0 then parity_odd=1, and check parity bit 0 then 1, each frame 44 clk.
REQ-034 Bench SHALL preload the FIFO with 0xA1,0xB2,0xC3 and check three frames in order, each gap exactly 2 clk of high txd after the stop bit, and rd_en never high with fifo_empty=1.
REQ-035 Bench SHALL hold fifo_empty=1 with tx_en=1 for 100 clk and check txd=1, busy=0, rd_en=0 throughout.
REQ-036 Bench SHALL assert rst for 1 cycle mid-DATA and check txd=1 and busy=0 on the next clk with no further rd_en, then check that a subsequent byte 0x0F transmits correctly.
REQ-037 Bench SHALL set baud_div=0 and check a bit period of 2 clk; it SHALL change baud_div 4->8 mid-frame and check the frame still uses 4.
